// File: rtl/lane_deskew_fifo_pkg.sv
// Shared definitions for the lane deskew buffer and its deskew controller.
// Memory entries carry the alignment-marker tag above the coded block.
package lane_deskew_fifo_pkg;

   localparam int NB_CODED_BLOCK_DEF = 66;
   localparam int NB_MEM_DATA        = NB_CODED_BLOCK_DEF + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT     = 2'd1,
      ST_DESKEWED = 2'd2
   } deskew_state_t;

endpackage

// File: rtl/lane_deskew_fifo_ram.sv
// Simple dual-port RAM for the deskew buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module deskew_ram #(
   parameter int NB_DATA = 67,
   parameter int DEPTH   = 20,
   parameter int NB_ADDR = $clog2(DEPTH)
) (
   input  logic               i_clock,
   input  logic               i_wr_en,
   input  logic [NB_ADDR-1:0] i_wr_addr,
   input  logic [NB_DATA-1:0] i_wr_data,
   input  logic               i_rd_en,
   input  logic [NB_ADDR-1:0] i_rd_addr,
   output logic [NB_DATA-1:0] o_rd_data
);

   logic [NB_DATA-1:0] mem_q [DEPTH];
   logic [NB_DATA-1:0] rd_data_q;

   always_ff @(posedge i_clock) begin
      if (i_rd_en) rd_data_q <= mem_q[i_rd_addr];
      if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/lane_deskew_fifo.sv
// Per-lane deskew buffer: captures the alignment-marker position, then replays
// the lane from that marker once every lane has seen its own marker.
module lane_deskew_fifo
   import lane_deskew_fifo_pkg::*;
#(
   parameter int NB_CODED_BLOCK = NB_CODED_BLOCK_DEF,
   parameter int FIFO_DEPTH     = 20,
   parameter int NB_ADDR        = $clog2(FIFO_DEPTH)
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_valid,
   input  logic [NB_CODED_BLOCK-1:0] i_data,
   input  logic                      i_aligner_tag,
   input  logic                      i_all_lanes_am,
   input  logic                      i_resync,
   output logic [NB_CODED_BLOCK-1:0] o_data,
   output logic                      o_valid,
   output logic                      o_aligner_tag,
   output logic                      o_am_seen,
   output logic                      o_deskewed,
   output logic                      o_overflow,
   output logic [NB_ADDR-1:0]        o_skew
);

   localparam int NB_MEM = NB_CODED_BLOCK + 1;
   localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(FIFO_DEPTH - 1);

   deskew_state_t      state_q, state_d;
   logic [NB_ADDR-1:0] wr_addr_q, wr_addr_d;
   logic [NB_ADDR-1:0] rd_addr_q, rd_addr_d;
   logic [NB_ADDR-1:0] am_addr_q, am_addr_d;
   logic [NB_ADDR-1:0] skew_cnt_q, skew_cnt_d;
   logic [NB_ADDR-1:0] skew_q, skew_d;
   logic               valid_q, valid_d;
   logic               am_seen_q, am_seen_d;
   logic               overflow_q, overflow_d;
   logic               live_q, live_d;
   logic               wr_en, rd_en;
   logic [NB_MEM-1:0]  rd_data;

   function automatic logic [NB_ADDR-1:0] ptr_inc(input logic [NB_ADDR-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + NB_ADDR'(1);
   endfunction

   assign wr_en = i_enable & i_valid;

   always_comb begin
      state_d    = state_q;
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      am_addr_d  = am_addr_q;
      skew_cnt_d = skew_cnt_q;
      skew_d     = skew_q;
      live_d     = live_q;
      valid_d    = 1'b0;
      am_seen_d  = 1'b0;
      overflow_d = 1'b0;
      rd_en      = 1'b0;
      if (i_enable) begin
         if (wr_en) wr_addr_d = ptr_inc(wr_addr_q);
         if (i_resync) begin
            state_d    = ST_IDLE;
            skew_cnt_d = '0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (wr_en && i_aligner_tag) begin
                     am_addr_d  = wr_addr_q;
                     skew_cnt_d = '0;
                     am_seen_d  = 1'b1;
                     state_d    = ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  // all-lanes-am takes precedence over an overflowing write
                  if (i_all_lanes_am) begin
                     rd_addr_d = am_addr_q;
                     skew_d    = skew_cnt_q;
                     state_d   = ST_DESKEWED;
                  end else if (wr_en) begin
                     if (skew_cnt_q == LAST_ADDR) begin
                        overflow_d = 1'b1;
                        skew_cnt_d = '0;
                        state_d    = ST_IDLE;
                     end else begin
                        skew_cnt_d = skew_cnt_q + NB_ADDR'(1);
                     end
                  end
               end
               ST_DESKEWED: begin
                  if (wr_en) begin
                     rd_en     = 1'b1;
                     rd_addr_d = ptr_inc(rd_addr_q);
                     valid_d   = 1'b1;
                     live_d    = 1'b1;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         am_addr_q  <= '0;
         skew_cnt_q <= '0;
         skew_q     <= '0;
         valid_q    <= 1'b0;
         am_seen_q  <= 1'b0;
         overflow_q <= 1'b0;
         live_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         am_addr_q  <= am_addr_d;
         skew_cnt_q <= skew_cnt_d;
         skew_q     <= skew_d;
         valid_q    <= valid_d;
         am_seen_q  <= am_seen_d;
         overflow_q <= overflow_d;
         live_q     <= live_d;
      end
   end

   deskew_ram #(
      .NB_DATA (NB_MEM),
      .DEPTH   (FIFO_DEPTH),
      .NB_ADDR (NB_ADDR)
   ) u_ram (
      .i_clock   (i_clock),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr_q),
      .i_wr_data ({i_aligner_tag, i_data}),
      .i_rd_en   (rd_en),
      .i_rd_addr (rd_addr_q),
      .o_rd_data (rd_data)
   );

   // RAM contents are not reset, so the data outputs stay zero until the first read
   assign o_data        = live_q ? rd_data[NB_CODED_BLOCK-1:0] : '0;
   assign o_aligner_tag = live_q ? rd_data[NB_MEM-1] : 1'b0;
   assign o_valid       = valid_q;
   assign o_am_seen     = am_seen_q;
   assign o_overflow    = overflow_q;
   assign o_skew        = skew_q;
   assign o_deskewed    = (state_q == ST_DESKEWED);

endmodule

// File: tb/tb_lane_deskew_fifo.sv
// Directed bench for lane_deskew_fifo: stimulus pushes expected blocks into
// per-lane queues, negedge monitors pop and compare whenever o_valid is high.
module tb_lane_deskew_fifo;

   logic        clk = 1'b0;
   logic        rst, en, vld, am, rs;
   logic [65:0] d0, d1;
   logic        t0, t1;

   logic [65:0] od0, od1;
   logic        ov0, ov1, ot0, ot1, os0, os1, odk0, odk1, oo0, oo1;
   logic [4:0]  sk0, sk1;

   int errors = 0;
   int checks = 0;

   logic [65:0] hd [0:2047];
   logic        ht [0:2047];
   logic [66:0] q0 [$];
   logic [66:0] q1 [$];

   always #5 clk = ~clk;

   lane_deskew_fifo #(.NB_CODED_BLOCK(66), .FIFO_DEPTH(20)) u0 (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_data(d0),
      .i_aligner_tag(t0), .i_all_lanes_am(am), .i_resync(rs),
      .o_data(od0), .o_valid(ov0), .o_aligner_tag(ot0), .o_am_seen(os0),
      .o_deskewed(odk0), .o_overflow(oo0), .o_skew(sk0));

   lane_deskew_fifo #(.NB_CODED_BLOCK(66), .FIFO_DEPTH(20)) u1 (
      .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_data(d1),
      .i_aligner_tag(t1), .i_all_lanes_am(am), .i_resync(rs),
      .o_data(od1), .o_valid(ov1), .o_aligner_tag(ot1), .o_am_seen(os1),
      .o_deskewed(odk1), .o_overflow(oo1), .o_skew(sk1));

   function automatic logic [65:0] mk(input int n);
      return {2'b01, 32'hC0DE0000 + 32'(n), 32'(n) ^ 32'h5A5A5A5A};
   endfunction

   task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock of stimulus; n selects block n for lane 0 and block n+1000 for lane 1
   task automatic step(input bit v, input int n, input bit tg, input bit a,
                       input bit tg1 = 1'b0, input bit e = 1'b1,
                       input bit r = 1'b0, input bit reset = 1'b0);
      hd[n] = mk(n);
      ht[n] = tg;
      hd[n+1000] = mk(n + 1000);
      ht[n+1000] = tg1;
      vld = v; d0 = hd[n]; t0 = tg; d1 = hd[n+1000]; t1 = tg1;
      am = a; en = e; rs = r; rst = reset;
      @(posedge clk);
      #1;
   endtask

   task automatic exp0(input int n);
      q0.push_back({ht[n], hd[n]});
   endtask

   task automatic exp1(input int n);
      q1.push_back({ht[n], hd[n]});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"}, {1'b0, od0}, '0);
      chk({tag, "_flags"}, {ov0, ot0, os0, odk0, oo0}, '0);
      chk({tag, "_skew"}, {62'd0, sk0}, '0);
   endtask

   always @(negedge clk) begin
      if (ov0) begin
         if (q0.size() == 0) chk("lane0_unexpected_out", {ot0, od0}, '1);
         else chk("lane0_out", {ot0, od0}, q0.pop_front());
      end
      if (ov1) begin
         if (q1.size() == 0) chk("lane1_unexpected_out", {ot1, od1}, '1);
         else chk("lane1_out", {ot1, od1}, q1.pop_front());
      end
   end

   initial begin
      int k;
      rst = 1'b1; en = 1'b1; vld = 1'b0; am = 1'b0; rs = 1'b0;
      d0 = '0; d1 = '0; t0 = 1'b0; t1 = 1'b0;

      // reset state
      step(0, 999, 0, 0, 0, 1, 0, 1);
      step(0, 999, 0, 0, 0, 1, 0, 1);
      chk_all_zero("reset");

      // marker at block 5, all-lanes-am three writes later
      for (int n = 0; n < 5; n++) step(1, n, 0, 0);
      step(1, 5, 1, 0);
      chk("am_seen_pulse", {66'd0, os0}, 67'd1);
      step(1, 6, 0, 0);
      chk("am_seen_once", {66'd0, os0}, 67'd0);
      step(1, 7, 0, 0);
      step(1, 8, 0, 0);
      chk("not_yet_deskewed", {66'd0, odk0}, 67'd0);
      step(1, 9, 0, 1);
      chk("deskewed_level", {66'd0, odk0}, 67'd1);
      chk("skew_3", {62'd0, sk0}, 67'd3);
      for (int n = 10; n < 20; n++) begin
         exp0(n - 5);
         step(1, n, (n == 15), 1);
         if (n == 10) chk("first_out_is_marker", {ov0, ot0, od0}, {2'b11, mk(5)});
         if (n == 15) chk("no_recapture", {66'd0, os0}, 67'd0);
      end
      step(0, 999, 0, 1);
      chk("no_strobe_no_valid", {66'd0, ov0}, 67'd0);

      // reset while deskewed
      step(0, 999, 0, 1, 0, 1, 0, 1);
      chk_all_zero("reset_mid_deskew");

      // marker at address 18, skew 6: reads wrap 19 -> 0
      for (int n = 40; n < 58; n++) step(1, n, 0, 0);
      step(1, 58, 1, 0);
      chk("recapture_after_reset", {66'd0, os0}, 67'd1);
      for (int n = 59; n < 65; n++) step(1, n, 0, 0);
      step(1, 65, 0, 1);
      chk("skew_6", {62'd0, sk0}, 67'd6);
      for (int n = 66; n < 76; n++) begin
         exp0(n - 8);
         step(1, n, 0, 1);
      end
      step(0, 999, 0, 0, 0, 1, 1);
      chk("resync_deskewed_low", {66'd0, odk0}, 67'd0);
      chk("resync_valid_low", {66'd0, ov0}, 67'd0);

      // overflow: marker, 19 writes, overflow on the 20th
      step(1, 80, 1, 0);
      chk("ovf_am_seen", {66'd0, os0}, 67'd1);
      for (int n = 81; n < 100; n++) begin
         step(1, n, 0, 0);
         chk("ovf_not_yet", {66'd0, oo0}, 67'd0);
      end
      step(1, 100, 1, 0);
      chk("ovf_pulse", {65'd0, oo0, os0}, 67'b10);
      step(1, 101, 0, 0);
      chk("ovf_one_cycle", {66'd0, oo0}, 67'd0);
      step(1, 102, 1, 0);
      chk("ovf_back_to_idle", {66'd0, os0}, 67'd1);
      step(0, 999, 0, 0, 0, 1, 1);

      // 50% valid duty with an enable drop while deskewed
      step(1, 110, 1, 0);
      chk("duty_am_seen", {66'd0, os0}, 67'd1);
      step(0, 999, 0, 0);
      step(1, 111, 0, 0);
      step(0, 999, 0, 0);
      step(1, 112, 0, 0);
      step(0, 999, 0, 0);
      step(1, 113, 0, 1);
      chk("duty_skew_2", {62'd0, sk0}, 67'd2);
      k = 110;
      for (int n = 114; n < 134; n++) begin
         exp0(k);
         k++;
         step(1, n, (n % 5 == 0), 1);
         chk("duty_valid_follows_strobe", {66'd0, ov0}, 67'd1);
         step(0, 999, 0, 1);
         chk("duty_gap_follows_input", {66'd0, ov0}, 67'd0);
         if (n == 120) begin
            for (int i = 0; i < 4; i++) begin
               step(1, 999, 0, 1, 0, 0);
               chk("enable_low_no_valid", {65'd0, ov0, odk0}, 67'b01);
            end
         end
      end
      step(0, 999, 0, 0, 0, 1, 1);

      // two lanes, markers 7 blocks apart, common all-lanes-am
      for (int n = 200; n < 214; n++) begin
         step(1, n, (n == 205), (n == 213), (n == 212));
         if (n == 205) chk("lane0_am_seen", {66'd0, os0}, 67'd1);
         if (n == 212) chk("lane1_am_seen", {66'd0, os1}, 67'd1);
      end
      chk("lane0_skew_7", {62'd0, sk0}, 67'd7);
      chk("lane1_skew_0", {62'd0, sk1}, 67'd0);
      for (int n = 214; n < 224; n++) begin
         exp0(n - 9);
         exp1(n + 1000 - 2);
         step(1, n, 0, 1);
         if (n == 214) chk("markers_aligned", {63'd0, ov0, ot0, ov1, ot1}, 67'hF);
      end
      step(0, 999, 0, 0);
      step(0, 999, 0, 0);
      chk("lane0_queue_drained", 67'(q0.size()), 67'd0);
      chk("lane1_queue_drained", 67'(q1.size()), 67'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
